// File: rtl/jam_pkg.sv
// Shared widths and state encoding for the job-assignment cost table.
package jam_pkg;

    localparam int N_WORKERS = 8;
    localparam int COST_W    = 7;
    localparam int TOTAL_W   = 10;
    localparam int IDX_W     = 3;
    localparam int N_ENTRIES = N_WORKERS * N_WORKERS;
    localparam int ADDR_W    = 2 * IDX_W;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRIES - 1);
    localparam logic [IDX_W-1:0]  LAST_COL = IDX_W'(N_WORKERS - 1);
    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic [1:0] {
        CT_IDLE  = 2'd0,
        CT_LOAD  = 2'd1,
        CT_READY = 2'd2
    } ct_state_e;

    function automatic logic [COST_W-1:0] min_cost(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cost_table_if.sv
// Load stream and lookup port of the cost table; master drives, slave is the table.
interface cost_table_if;
    import jam_pkg::*;

    logic                Start;
    logic                LoadValid;
    logic [COST_W-1:0]   LoadData;
    logic                LoadReady;
    logic [IDX_W-1:0]    W;
    logic [IDX_W-1:0]    J;
    logic [COST_W-1:0]   Cost;
    logic                TableReady;
    logic [TOTAL_W-1:0]  RowMinSum;

    modport master (
        output Start, LoadValid, LoadData, W, J,
        input  LoadReady, Cost, TableReady, RowMinSum
    );

    modport slave (
        input  Start, LoadValid, LoadData, W, J,
        output LoadReady, Cost, TableReady, RowMinSum
    );

endinterface

// File: rtl/cost_rowmin_acc.sv
// Running per-row minimum and lower-bound accumulator for the cost table.
// Only compiled when COST_TABLE_ROWMIN_EN is defined.
`ifdef COST_TABLE_ROWMIN_EN
module cost_rowmin_acc
    import jam_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                xfer,
    input  logic [IDX_W-1:0]    col,
    input  logic [COST_W-1:0]   data,
    output logic [TOTAL_W-1:0]  sum
);

    logic [COST_W-1:0]  min_q, min_d;
    logic [TOTAL_W-1:0] acc_q, acc_d;
    logic [COST_W-1:0]  row_min;

    always_comb begin
        min_d   = min_q;
        acc_d   = acc_q;
        // Column 0 starts a fresh row, so the stale minimum is dropped.
        row_min = (col == '0) ? data : min_cost(min_q, data);
        if (clear) begin
            min_d = COST_MAX;
            acc_d = '0;
        end else if (xfer) begin
            min_d = row_min;
            if (col == LAST_COL) begin
                acc_d = acc_q + TOTAL_W'(row_min);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            min_q <= COST_MAX;
            acc_q <= '0;
        end else begin
            min_q <= min_d;
            acc_q <= acc_d;
        end
    end

    assign sum = acc_q;

endmodule
`endif

// File: rtl/cost_table.sv
// 64-entry worker x job cost table: streamed load, zero-latency lookup.
// Optional row-minimum lower bound under COST_TABLE_ROWMIN_EN.
//
// state    | meaning
// CT_IDLE  | no table loaded since reset
// CT_LOAD  | accepting entries, cnt = next entry index
// CT_READY | all 64 entries loaded, Cost valid
module cost_table
    import jam_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    cost_table_if.slave  bus
);

    ct_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                table_ready_q, table_ready_d;
    logic [COST_W-1:0]   cost_mem_q [N_ENTRIES];
    logic                load_ready;
    logic                xfer;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_ready = (state_q == CT_LOAD);
        // Start wins over a coincident transfer.
        xfer       = bus.LoadValid && load_ready && !bus.Start;
        unique case (state_q)
            CT_IDLE: begin
                if (bus.Start) begin
                    state_d = CT_LOAD;
                    cnt_d   = '0;
                end
            end
            CT_LOAD: begin
                if (bus.Start) begin
                    cnt_d = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = CT_READY;
                    end
                end
            end
            CT_READY: begin
                if (bus.Start) begin
                    state_d = CT_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CT_IDLE;
                cnt_d   = '0;
            end
        endcase
        table_ready_d = (state_d == CT_READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= CT_IDLE;
            cnt_q         <= '0;
            table_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            table_ready_q <= table_ready_d;
        end
    end

    // Table storage has no reset; a reset during load must not leave a partial write.
    always_ff @(posedge CLK) begin
        if (xfer && !RST) begin
            cost_mem_q[cnt_q] <= bus.LoadData;
        end
    end

    assign bus.LoadReady  = load_ready;
    assign bus.TableReady = table_ready_q;
    assign bus.Cost       = table_ready_q ? cost_mem_q[{bus.W, bus.J}] : '0;

`ifdef COST_TABLE_ROWMIN_EN
    cost_rowmin_acc u_rowmin (
        .CLK   (CLK),
        .RST   (RST),
        .clear (bus.Start),
        .xfer  (xfer),
        .col   (cnt_q[IDX_W-1:0]),
        .data  (bus.LoadData),
        .sum   (bus.RowMinSum)
    );
`else
    assign bus.RowMinSum = '0;
`endif

endmodule

// File: tb/tb_cost_table.sv
// Directed bench for cost_table with an expected-value scoreboard queue.
module tb_cost_table;
    import jam_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cost_table_if bus();

    cost_table dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [6:0]  model [64];
    int          mstate = 0;   // 0 idle, 1 load, 2 ready
    int          mcnt   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    // One clock: drive inputs, check outputs against the bench model, advance the model.
    task automatic cycle(input bit start, input bit v, input logic [6:0] d,
                         input int w, input int j);
        bus.Start     = start;
        bus.LoadValid = v;
        bus.LoadData  = d;
        bus.W         = 3'(w);
        bus.J         = 3'(j);
        #1;
        expect_val(16'(mstate == 1));
        chk("load_ready", 16'(bus.LoadReady));
        expect_val(16'(mstate == 2));
        chk("table_ready", 16'(bus.TableReady));
        expect_val((mstate == 2) ? 16'(model[w*8+j]) : 16'd0);
        chk("cost", 16'(bus.Cost));
        tick();
        if (start) begin
            mstate = 1;
            mcnt   = 0;
        end else if (mstate == 1 && v) begin
            model[mcnt] = d;
            if (mcnt == 63) begin
                mstate = 2;
                mcnt   = 0;
            end else begin
                mcnt++;
            end
        end
    endtask

    task automatic probe(input string tag, input int w, input int j, input logic [15:0] e);
        bus.W = 3'(w);
        bus.J = 3'(j);
        #1;
        expect_val(e);
        chk(tag, 16'(bus.Cost));
    endtask

    task automatic chk_rowmin();
        logic [15:0] s;
        logic [6:0]  m;
        s = 16'd0;
`ifdef COST_TABLE_ROWMIN_EN
        for (int w = 0; w < 8; w++) begin
            m = 7'h7F;
            for (int j = 0; j < 8; j++) if (model[w*8+j] < m) m = model[w*8+j];
            s = s + 16'(m);
        end
`endif
        expect_val(s);
        chk("row_min_sum", 16'(bus.RowMinSum));
    endtask

    task automatic sweep(input bit v);
        for (int i = 0; i < 64; i++) cycle(1'b0, v, 7'h7F, i / 8, i % 8);
    endtask

    task automatic check_reset_outputs(input string tag);
        expect_val(16'd0); chk({tag, "_load_ready"},  16'(bus.LoadReady));
        expect_val(16'd0); chk({tag, "_table_ready"}, 16'(bus.TableReady));
        expect_val(16'd0); chk({tag, "_cost"},        16'(bus.Cost));
        expect_val(16'd0); chk({tag, "_row_min_sum"}, 16'(bus.RowMinSum));
    endtask

    initial begin
        int acc;
        int k;
        bit v;
        bus.Start = 0; bus.LoadValid = 0; bus.LoadData = '0; bus.W = '0; bus.J = '0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        bus.W = 3'd5; bus.J = 3'd2;
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        mstate = 0; mcnt = 0;

        // LoadValid in IDLE: ignored, Cost stays 0 across W/J
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 7'h55, i, 7 - i);

        // Full load with W+J, LoadValid held high
        cycle(1'b1, 1'b0, 7'h00, 0, 0);
        for (int i = 0; i < 64; i++)
            cycle(1'b0, 1'b1, 7'((i / 8) + (i % 8)), $urandom_range(7), $urandom_range(7));
        probe("cost_w3_j5", 3, 5, 16'd8);
        chk_rowmin();

        // LoadValid in READY must not write; full sweep of the table
        sweep(1'b1);

        // Restart from READY, LoadValid toggling every other cycle
        cycle(1'b1, 1'b0, 7'h00, 1, 1);
        acc = 0; k = 0;
        while (acc < 64 && k < 300) begin
            v = (k % 2 == 0);
            cycle(1'b0, v, v ? 7'((acc * 5 + 3) & 127) : 7'($urandom_range(127)),
                  $urandom_range(7), $urandom_range(7));
            if (v) acc++;
            k++;
        end
        expect_val(16'd64);
        chk("accepted_count", 16'(acc));
        probe("cost_last_entry", 7, 7, 16'd62);
        chk_rowmin();
        sweep(1'b0);

        // Restart mid-load: Start coincident with a transfer discards it
        cycle(1'b1, 1'b0, 7'h00, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 7'(i + 40), 0, 0);
        cycle(1'b1, 1'b1, 7'h11, 0, 0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, 7'((i * 3 + 9) & 127), 2, 6);
        probe("cost_first_after_restart", 0, 0, 16'd9);
        chk_rowmin();
        sweep(1'b0);

        // Row minimum pattern: row w is 10+w except diagonal w
        cycle(1'b1, 1'b0, 7'h00, 0, 0);
        for (int i = 0; i < 64; i++)
            cycle(1'b0, 1'b1, ((i / 8) == (i % 8)) ? 7'(i / 8) : 7'(10 + i / 8), 0, 0);
`ifdef COST_TABLE_ROWMIN_EN
        expect_val(16'd28);
`else
        expect_val(16'd0);
`endif
        chk("row_min_sum_diag", 16'(bus.RowMinSum));
        probe("cost_diag_w4", 4, 4, 16'd4);
        probe("cost_offdiag_w4", 4, 1, 16'd14);

        // Reset in the middle of a load
        cycle(1'b1, 1'b0, 7'h00, 0, 0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 7'h33, 0, 0);
        rst = 1'b1;
        bus.LoadValid = 1'b1;
        tick();
        bus.W = 3'd4; bus.J = 3'd4;
        #1;
        check_reset_outputs("midload_reset");
        rst = 1'b0;
        mstate = 0; mcnt = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 7'h22, 1, 2);
        cycle(1'b1, 1'b0, 7'h00, 0, 0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, 7'((i * 7 + 1) & 127), 0, 0);
        probe("cost_after_reload", 0, 0, 16'd1);
        chk_rowmin();
        sweep(1'b0);

        expect_val(16'd0);
        chk("scoreboard_drained", 16'(exp_q.size() - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cost_table.md
COST_TABLE -- requirements
Module: cost_table

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state rising-edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Start, input, 1, single-cycle pulse to begin or restart a 64-entry table load.
REQ-004 SHALL have port LoadValid, input, 1, LoadData is valid this cycle.
REQ-005 SHALL have port LoadData, input, 7, cost entry; row-major order, index = W*8+J.
REQ-006 SHALL have port LoadReady, output, 1, block accepts LoadData this cycle.
REQ-007 SHALL have port W, input, 3, worker index from the assignment engine.
REQ-008 SHALL have port J, input, 3, job index from the assignment engine.
REQ-009 SHALL have port Cost, output, 7, cost of (W,J).
REQ-010 SHALL have port TableReady, output, 1, table fully loaded and Cost valid.
REQ-011 SHALL have port RowMinSum, output, 10, sum of per-worker minimum costs (lower bound).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, READY.
REQ-013 SHALL transition IDLE->LOAD on Start; LOAD->READY on the 64th accepted entry; READY->LOAD on Start.
REQ-014 SHALL, on Start in LOAD, clear the entry counter to 0 and continue in LOAD (restart).
REQ-015 SHALL drive LoadReady=1 only in LOAD; a transfer occurs when LoadValid && LoadReady.
REQ-016 SHALL write LoadData to entry cnt on each transfer and increment the 6-bit counter cnt; cnt wraps 63->0 with the move to READY.
REQ-017 SHALL ignore LoadValid outside LOAD and ignore Start coincident with the final transfer only if... no: Start has priority -- Start coincident with any transfer discards that transfer and restarts at cnt=0.
REQ-018 SHALL drive TableReady as a registered signal, 1 exactly in READY; it rises the cycle after the 64th transfer and falls the cycle after Start.
REQ-019 SHALL drive Cost combinationally = table[W*8+J] when TableReady=1 (zero-cycle latency: Cost valid in the same cycle as W/J), else 7'd0.
REQ-020 SHALL not alter any table entry outside transfers.

Reset
REQ-021 SHALL on RST: state IDLE, cnt=0, LoadReady=0, TableReady=0, Cost=0, RowMinSum=0; table contents need not reset.
REQ-022 SHALL abandon any load in progress on RST; a new Start is required.

Configuration
REQ-023 SHALL, with COST_TABLE_ROWMIN_EN defined, keep a 7-bit running row minimum (reset to 127 at each J=0 entry) and, on each J=7 transfer, add the row minimum to a 10-bit accumulator cleared on Start; RowMinSum = accumulator, valid when TableReady=1 (max 8*127=1016, no overflow).
REQ-024 SHALL, without COST_TABLE_ROWMIN_EN, tie RowMinSum to 10'd0 and instantiate no minimum logic; port list identical.

Structure
REQ-025 SHALL take from shared package jam_pkg: N_WORKERS=8, COST_W=7, TOTAL_W=10, IDX_W=3, and the cost_table state enum.
REQ-026 SHALL place the row-minimum accumulator in sub-module cost_rowmin_acc, instantiated only under COST_TABLE_ROWMIN_EN.

Verification
REQ-027 SHALL cover: Start, 64 transfers LoadData=(W+J) with LoadValid held high -> TableReady rises cycle after 64th; W=3,J=5 -> Cost=8 same cycle.
REQ-028 SHALL cover: LoadValid toggling every other cycle -> exactly 64 accepted entries, table[63]=last accepted value, TableReady never early.
REQ-029 SHALL cover: Start after 20 transfers -> cnt restarts; following 64 transfers fully overwrite; W=0,J=0 -> Cost equals first value after restart.
REQ-030 SHALL cover: W/J swept before TableReady -> Cost=0; LoadValid in IDLE/READY -> no writes, LoadReady=0.
REQ-031 SHALL cover (ROWMIN_EN): row w entries = 10+w except table[w*8+w]=w -> RowMinSum=28; without macro -> RowMinSum=0.
REQ-032 SHALL cover: RST asserted mid-load (after 30 transfers) -> all outputs reset values next cycle; full reload then yields correct Cost.
